// File: rtl/cic_pkg.sv
// Shared widths, defaults and sample format for the running-sum decimator
// and the sample framer that consumes its final-stage output.
package cic_pkg;

    localparam int CIC_OUT_W = 12;
    localparam int SEQ_W     = 8;

    localparam int                   DEF_DECIM_PERIOD = 9;
    localparam logic [CIC_OUT_W-1:0] DEF_OFFSET       = 12'd2048;

    typedef struct packed {
        logic [CIC_OUT_W-1:0] data;
        logic [SEQ_W-1:0]     seq;
    } sample_t;

    localparam int SAMPLE_W = $bits(sample_t);

    // Unsigned minus unsigned, result clamped into the signed CIC_OUT_W range.
    // A one-bit-wider difference is out of range exactly when its top two bits differ.
    function automatic logic [CIC_OUT_W-1:0] sat_sub(
        input logic [CIC_OUT_W-1:0] a,
        input logic [CIC_OUT_W-1:0] b
    );
        logic [CIC_OUT_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[CIC_OUT_W] != diff[CIC_OUT_W-1]) begin
            sat_sub = {diff[CIC_OUT_W], {(CIC_OUT_W-1){~diff[CIC_OUT_W]}}};
        end else begin
            sat_sub = diff[CIC_OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    // Head is forced to zero while empty so the outputs read zero out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cic_sample_framer.sv
// Samples the decimator output once per period, removes the DC offset with
// saturation, tags it with a sequence number and queues it on a valid/ready stream.
module cic_sample_framer
    import cic_pkg::*;
#(
    parameter int                   DECIM_PERIOD  = DEF_DECIM_PERIOD,
    parameter int                   CAPTURE_PHASE = 0,
    parameter logic [CIC_OUT_W-1:0] OFFSET        = DEF_OFFSET,
    parameter int                   FIFO_DEPTH    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CIC_OUT_W-1:0]          cic_in,
    output logic [CIC_OUT_W-1:0]          m_data,
    output logic [SEQ_W-1:0]              m_seq,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          overflow,
    input  logic                          ovf_clr,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int PW = (DECIM_PERIOD > 1) ? $clog2(DECIM_PERIOD) : 1;

    logic [PW-1:0]    phase;
    logic             primed;
    logic             wrap;
    logic             capture;
    logic [SEQ_W-1:0] seq_cnt;
    sample_t          stage1;
    logic             stage1_valid;
    sample_t          head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             drop;

    assign wrap    = (phase == PW'(DECIM_PERIOD - 1));
    assign capture = primed && (phase == PW'(CAPTURE_PHASE));

    // The value present during the reset-period phases is never captured:
    // capture waits until the phase counter has wrapped once.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase        <= '0;
            primed       <= 1'b0;
            seq_cnt      <= '0;
            stage1       <= '0;
            stage1_valid <= 1'b0;
        end else begin
            phase        <= wrap ? '0 : phase + 1'b1;
            stage1_valid <= capture;
            if (wrap) begin
                primed <= 1'b1;
            end
            if (capture) begin
                stage1.data <= sat_sub(cic_in, OFFSET);
                stage1.seq  <= seq_cnt;
                seq_cnt     <= seq_cnt + 1'b1;
            end
        end
    end

    assign pop  = m_valid && m_ready;
    assign drop = stage1_valid && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (stage1_valid),
        .wr_data (stage1),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = head.data;
    assign m_seq   = head.seq;

endmodule

// File: tb/tb_cic_sample_framer.sv
// Directed bench for cic_sample_framer: stimulus pushes expected samples into
// scoreboard queues, negedge monitors pop and compare on each handshake.
module tb_cic_sample_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] cic_in;
    logic        m_ready;
    logic        ovf_clr;
    logic [11:0] m_data;
    logic [7:0]  m_seq;
    logic        m_valid;
    logic        overflow;
    logic [3:0]  level;

    logic [11:0] va_data, vb_data, vc_data;
    logic [7:0]  va_seq, vb_seq, vc_seq;
    logic        va_valid, vb_valid, vc_valid;
    logic        va_ovf, vb_ovf, vc_ovf;
    logic [3:0]  va_level, vb_level, vc_level;

    int          total = 0;
    int          bad = 0;
    int          ecount = 0;
    logic [7:0]  exp_seq;
    logic [19:0] sb [$];
    logic [19:0] va_q [$];
    logic [19:0] vb_q [$];
    logic [19:0] vc_q [$];
    logic [19:0] sb_e, va_e, vb_e, vc_e;

    logic [11:0] in_tab  [8] = '{12'd2048, 12'd2049, 12'd2047, 12'd0,
                                 12'd4095, 12'd1024, 12'd3072, 12'd2148};
    logic [11:0] exp_tab [8] = '{12'd0,    12'd1,    12'hFFF,  12'h800,
                                 12'h7FF,  12'hC00,  12'd1024, 12'd100};

    always #5 clk = ~clk;

    cic_sample_framer dut (
        .clk(clk), .rst(rst), .cic_in(cic_in), .m_data(m_data), .m_seq(m_seq),
        .m_valid(m_valid), .m_ready(m_ready), .overflow(overflow),
        .ovf_clr(ovf_clr), .level(level)
    );

    cic_sample_framer #(.OFFSET(12'd100)) dut_a (
        .clk(clk), .rst(rst), .cic_in(12'd0), .m_data(va_data), .m_seq(va_seq),
        .m_valid(va_valid), .m_ready(1'b1), .overflow(va_ovf),
        .ovf_clr(1'b0), .level(va_level)
    );

    cic_sample_framer #(.OFFSET(12'd0)) dut_b (
        .clk(clk), .rst(rst), .cic_in(12'd4095), .m_data(vb_data), .m_seq(vb_seq),
        .m_valid(vb_valid), .m_ready(1'b1), .overflow(vb_ovf),
        .ovf_clr(1'b0), .level(vb_level)
    );

    cic_sample_framer #(.OFFSET(12'd4095)) dut_c (
        .clk(clk), .rst(rst), .cic_in(12'd0), .m_data(vc_data), .m_seq(vc_seq),
        .m_valid(vc_valid), .m_ready(1'b1), .overflow(vc_ovf),
        .ovf_clr(1'b0), .level(vc_level)
    );

    // Edges since reset release: edge k leaves ecount == k.
    always @(posedge clk) begin
        if (rst) ecount <= 0;
        else     ecount <= ecount + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got seq %0d data 0x%0h, none expected", m_seq, m_data);
            end else begin
                sb_e = sb.pop_front();
                check("sb_data", 32'(m_data), 32'(sb_e[19:8]));
                check("sb_seq", 32'(m_seq), 32'(sb_e[7:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && va_valid && va_q.size() > 0) begin
            va_e = va_q.pop_front();
            check("off100_data", 32'(va_data), 32'(va_e[19:8]));
            check("off100_seq", 32'(va_seq), 32'(va_e[7:0]));
        end
        if (!rst && vb_valid && vb_q.size() > 0) begin
            vb_e = vb_q.pop_front();
            check("off0_sat_data", 32'(vb_data), 32'(vb_e[19:8]));
            check("off0_sat_seq", 32'(vb_seq), 32'(vb_e[7:0]));
        end
        if (!rst && vc_valid && vc_q.size() > 0) begin
            vc_e = vc_q.pop_front();
            check("negsat_data", 32'(vc_data), 32'(vc_e[19:8]));
            check("negsat_seq", 32'(vc_seq), 32'(vc_e[7:0]));
        end
    end

    // Advance to #1 after edge k (relative to the last reset release).
    task automatic go_to(input int k);
        int guard;
        guard = 0;
        while (ecount < k) begin
            @(posedge clk);
            #1;
            guard++;
            if (guard > 2000) begin
                $display("FAIL go_to_timeout: got edge %0d expected edge %0d", ecount, k);
                $fatal(1, "edge wait expired");
            end
        end
    endtask

    // Present v for the next capture edge; if keep, expect d with the current sequence number.
    task automatic cap(input logic [11:0] v, input logic [11:0] d, input bit keep);
        int k;
        cic_in = v;
        k = (ecount < 10) ? 10 : 10 + ((ecount - 10) / 9 + 1) * 9;
        go_to(k);
        if (keep) sb.push_back({d, exp_seq});
        exp_seq++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        exp_seq = '0;
    endtask

    initial begin
        rst     = 1'b1;
        m_ready = 1'b1;
        ovf_clr = 1'b0;
        cic_in  = 12'd2048;
        exp_seq = '0;
        va_q.push_back({12'hF9C, 8'd0});
        va_q.push_back({12'hF9C, 8'd1});
        vb_q.push_back({12'h7FF, 8'd0});
        vb_q.push_back({12'h7FF, 8'd1});
        vc_q.push_back({12'h800, 8'd0});
        vc_q.push_back({12'h800, 8'd1});
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_seq", 32'(m_seq), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_level", 32'(level), 32'd0);

        // Free-running stream with the consumer always ready.
        cap(12'd2048, 12'd0, 1'b1);
        check("lat_e10_valid", 32'(m_valid), 32'd0);
        go_to(11);
        check("lat_e11_valid", 32'(m_valid), 32'd1);
        cap(12'd2048, 12'd0, 1'b1);
        cap(12'd4095, 12'h7FF, 1'b1);
        cap(12'd0, 12'h800, 1'b1);
        cap(12'd3000, 12'd952, 1'b1);
        cap(12'd1000, 12'hBE8, 1'b1);
        go_to(57);
        check("drain_level", 32'(level), 32'd0);

        // Stalled consumer: fill to depth, drop the ninth sample.
        m_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 8; i++) cap(in_tab[i], exp_tab[i], 1'b1);
        go_to(74);
        check("full_level", 32'(level), 32'd8);
        check("full_no_ovf", 32'(overflow), 32'd0);
        cap(12'd123, 12'd0, 1'b0);
        ovf_clr = 1'b1;
        go_to(83);
        ovf_clr = 1'b0;
        check("ovf_set_over_clr", 32'(overflow), 32'd1);
        check("drop_level", 32'(level), 32'd8);
        go_to(84);
        ovf_clr = 1'b1;
        go_to(85);
        ovf_clr = 1'b0;
        check("ovf_clr_alone", 32'(overflow), 32'd0);

        // Pop exactly on the write edge while full.
        cap(12'd2000, 12'hFD0, 1'b1);
        m_ready = 1'b1;
        go_to(92);
        m_ready = 1'b0;
        check("pushpop_full_ovf", 32'(overflow), 32'd0);
        check("pushpop_full_level", 32'(level), 32'd8);
        m_ready = 1'b1;
        cap(12'd2500, 12'd452, 1'b1);
        go_to(102);
        check("refill_drain_level", 32'(level), 32'd0);

        // Reset with three samples queued.
        m_ready = 1'b0;
        cap(12'd1900, 12'hF6C, 1'b1);
        cap(12'd1950, 12'hF9E, 1'b1);
        cap(12'd2010, 12'hFDA, 1'b1);
        go_to(128);
        check("queued_level", 32'(level), 32'd3);
        do_reset();
        check("midrst_valid", 32'(m_valid), 32'd0);
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        m_ready = 1'b1;
        cap(12'd2100, 12'd52, 1'b1);
        check("relat_e10_valid", 32'(m_valid), 32'd0);
        go_to(11);
        check("relat_e11_valid", 32'(m_valid), 32'd1);
        go_to(13);

        check("sb_leftover", 32'(sb.size()), 32'd0);
        check("off100_leftover", 32'(va_q.size()), 32'd0);
        check("off0_leftover", 32'(vb_q.size()), 32'd0);
        check("negsat_leftover", 32'(vc_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cic_sample_framer.md
# cic_sample_framer

Downstream stage of the 3-stage recursive running-sum decimator: samples the decimator's 12-bit final-stage output (out3) once per decimation period, removes the DC offset with saturation, tags each sample with a sequence number and buffers it in a small FIFO behind a valid/ready stream toward the beamforming/capture logic. It shares clock and reset with the decimator and derives the capture instant from its own phase counter, released by the same reset.

## Interface
- DECIM_PERIOD, 9: clocks per decimator output update (decimator counts 0..8).
- CAPTURE_PHASE, 0: phase-counter value at which out3 is sampled.
- OFFSET, 12'd2048: unsigned midscale subtracted from each sample.
- FIFO_DEPTH, 8: entries, power of two, ≥2.
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- cic_in  in  12  decimator final-stage output, treated as unsigned.
- m_data  out  12  signed, offset-corrected sample.
- m_seq  out  8  sequence number of m_data.
- m_valid  out  1  FIFO head valid.
- m_ready  in  1  consumer accepts head.
- overflow  out  1  sticky: at least one sample dropped.
- ovf_clr  in  1  clears overflow.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Phase counter: 0 at reset, +1 per clock, wraps DECIM_PERIOD-1 → 0. Decimator updates out3 at edges 9, 18, …; with CAPTURE_PHASE=0, the new value is stable when the phase reads 0.
- primed flag: 0 at reset, set at the first wrap. A capture occurs at an edge where phase==CAPTURE_PHASE and primed=1. The reset-state sample is therefore never captured.
- Stage 1 (capture edge): diff = {1'b0,cic_in} - {1'b0,OFFSET} as signed 13-bit. Saturate to the signed 12-bit range [-2048, 2047]. Register the result with seq_cnt; seq_cnt increments by 1 and wraps 255→0. stage1_valid is set.
- Stage 2 (next edge): push {data,seq} into the FIFO if it is not full. If the FIFO is full and no pop occurs in the same cycle, drop the sample and set overflow. seq_cnt still advances, so dropped samples appear as gaps in m_seq.
- Pop: m_valid && m_ready at an edge removes the head.
- Simultaneous push and pop when full: both occur, no drop, level unchanged. Simultaneous push and pop when empty: the push lands and the pop is impossible because m_valid=0.
- overflow: set has priority over ovf_clr in the same cycle.
- FIFO is first-word-fall-through: m_data and m_seq are valid whenever m_valid=1, and they hold stable while m_valid && !m_ready.

## Timing
- Reset values: m_valid=0, m_data=0, m_seq=0, overflow=0, level=0. Phase counter, seq_cnt, primed and stage1_valid are all 0.
- Reset mid-operation flushes the FIFO and the stage-1 register and restarts the phase counter, staying aligned with the decimator. A sample in flight is discarded without setting overflow.
- Latency: capture edge E → FIFO write at E+1 → m_valid=1 after E+1 (when the FIFO was empty).
- With defaults, the first capture is at edge 10 after reset release and the first m_valid is after edge 11. Captures then occur every 9 clocks.
- Throughput: one sample per DECIM_PERIOD. A consumer holding m_ready low for longer than FIFO_DEPTH×DECIM_PERIOD clocks causes drops.
- level updates on the same edge as a push or pop.

## Structure
- Package cic_pkg: CIC_OUT_W=12, SEQ_W=8, the default DECIM_PERIOD and OFFSET, and a sample struct/width {data[11:0], seq[7:0]}. The decimator reuses CIC_OUT_W and DECIM_PERIOD from this package.
- Sub-module sync_fifo (parameterised width/depth, FWFT, full/empty/level, registered storage). The framer instantiates one instance of sync_fifo at width 20.
- The top contains the phase counter, primed flag, saturating subtractor, seq counter and overflow logic.

## Test plan
- Reset, then hold cic_in=12'd2048 and m_ready=1 → first m_valid after edge 11, m_data=0, m_seq=0; subsequent samples every 9 clocks with m_seq 1, 2, 3, ….
- cic_in=12'd4095, then 12'd0 → m_data=2047, then -2048. With OFFSET=12'd100 and cic_in=0 → m_data=-100. With OFFSET=0 and cic_in=4095 → saturates to 2047.
- m_ready=0 for 9 captures (depth 8) → level reaches 8, the 9th sample is dropped and overflow=1. After m_ready=1, m_seq reads 0..7, then 9 (gap); 8 is never seen.
- FIFO full, m_ready pulsed exactly on the stage-2 write cycle → no drop, overflow stays 0, level stays 8.
- ovf_clr asserted alone → overflow=0 next edge. ovf_clr coincident with a drop → overflow stays 1.
- rst asserted for 1 clock mid-stream with 3 queued samples → m_valid=0 and level=0 after the reset edge. The next m_valid appears 11 edges after reset release with m_seq=0.
